// File: rtl/down_counter_pkg.sv
// Shared definitions for the loadable down-counter: state encodings and default width.
package down_counter_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/down_counter_ce_if.sv
// Control/data bundle for down_counter_ce; master drives load/enable, slave returns count and flags.
interface down_counter_ce_if #(
  parameter int WIDTH = 8
);
  logic             CE;
  logic             LOAD;
  logic             AUTO;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] O;
  logic             TC;
  logic             RUNNING;

  modport master (output CE, LOAD, AUTO, D, input  O, TC, RUNNING);
  modport slave  (input  CE, LOAD, AUTO, D, output O, TC, RUNNING);
endinterface

// File: rtl/decn_chain.sv
// Combinational decrementer: a + all-ones built from per-bit LUT4 sum and CARRY cells.
module decn_chain
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  // LUT4 with INIT C33C computes I1 ^ I2 ^ I3; I2 is the constant-one addend bit.
  localparam logic [15:0] LUT_INIT = 16'hC33C;

  logic [WIDTH-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign y[i] = LUT_INIT[{carry[i], 1'b1, a[i], 1'b0}];
    // CARRY cell with I1 tied high reduces to a | ci; the final borrow is dropped.
    if (i < WIDTH - 1) begin : g_cy
      assign carry[i+1] = a[i] | carry[i];
    end
  end

endmodule

// File: rtl/down_counter_ce.sv
// Loadable down-counter with clock enable, terminal-count pulse and optional auto-reload.
module down_counter_ce
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              CLK,
  input  logic              RST,
  down_counter_ce_if.slave  bus
);

  state_t           state_q;
  logic [WIDTH-1:0] o_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;
  logic [WIDTH-1:0] o_dec;
  logic             at_one;

  decn_chain #(.WIDTH(WIDTH)) u_dec (
    .a (o_q),
    .y (o_dec)
  );

  assign at_one = (o_q == WIDTH'(1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      o_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else if (bus.LOAD) begin
      reload_q <= bus.D;
      o_q      <= bus.D;
      tc_q     <= 1'b0;
      state_q  <= (bus.D != '0) ? RUN : IDLE;
    end else begin
      tc_q <= 1'b0;
      // Only RUN reacts to CE; IDLE and DONE park at zero until the next load.
      if (state_q == RUN && bus.CE) begin
        if (at_one) begin
          tc_q <= 1'b1;
          if (bus.AUTO) begin
            o_q <= reload_q;
          end else begin
            o_q     <= '0;
            state_q <= DONE;
          end
        end else begin
          o_q <= o_dec;
        end
      end
    end
  end

  assign bus.O       = o_q;
  assign bus.TC      = tc_q;
  assign bus.RUNNING = (state_q == RUN);

endmodule

// File: tb/tb_down_counter_ce.sv
// Bench for down_counter_ce: directed scenarios plus random traffic against a behavioural model.
module tb_down_counter_ce;

  logic clk = 1'b0;
  logic rst8;
  logic rst16;

  always #5 clk = ~clk;

  down_counter_ce_if #(.WIDTH(8))  ifc8  ();
  down_counter_ce_if #(.WIDTH(16)) ifc16 ();

  down_counter_ce #(.WIDTH(8)) u_dut8 (
    .CLK (clk),
    .RST (rst8),
    .bus (ifc8)
  );

  down_counter_ce #(.WIDTH(16)) u_dut16 (
    .CLK (clk),
    .RST (rst16),
    .bus (ifc16)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: count value, reload value, and whether the timer is counting.
  int m_o      = 0;
  int m_reload = 0;
  bit m_tc     = 0;
  bit m_run    = 0;
  int tc_seen  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_step(input bit r, input bit ld, input bit ce, input bit au, input int d);
    if (r) begin
      m_o = 0; m_reload = 0; m_tc = 0; m_run = 0;
    end else if (ld) begin
      m_reload = d; m_o = d; m_tc = 0; m_run = (d != 0);
    end else begin
      m_tc = 0;
      if (m_run && ce) begin
        if (m_o == 1) begin
          m_tc = 1;
          if (au) m_o = m_reload;
          else begin
            m_o   = 0;
            m_run = 0;
          end
        end else begin
          m_o = m_o - 1;
        end
      end
    end
  endtask

  // One clock on the 8-bit DUT, then compare all outputs with the model.
  task automatic cyc(input string tag, input bit r, input bit ld, input bit ce, input bit au,
                     input int d);
    rst8 = r; ifc8.LOAD = ld; ifc8.CE = ce; ifc8.AUTO = au; ifc8.D = d[7:0];
    @(posedge clk);
    model_step(r, ld, ce, au, d & 8'hFF);
    #1;
    chk({tag, ".O"},       32'(ifc8.O),       32'(m_o));
    chk({tag, ".TC"},      32'(ifc8.TC),      32'(m_tc));
    chk({tag, ".RUNNING"}, 32'(ifc8.RUNNING), 32'(m_run));
    if (ifc8.TC) tc_seen++;
  endtask

  initial begin
    rst8 = 1'b1; ifc8.LOAD = 1'b0; ifc8.CE = 1'b0; ifc8.AUTO = 1'b0; ifc8.D = '0;
    rst16 = 1'b1; ifc16.LOAD = 1'b0; ifc16.CE = 1'b0; ifc16.AUTO = 1'b0; ifc16.D = '0;
    #1;

    // Reset dominates a simultaneous load; CE afterwards must not wrap from zero.
    cyc("rst", 1, 1, 0, 0, 8'h55);
    cyc("rst", 1, 1, 0, 0, 8'h55);
    chk("rst.O0", 32'(ifc8.O), 32'h0);
    rst16 = 1'b0;
    for (int i = 0; i < 3; i++) cyc("idle_ce", 0, 0, 1, 0, 0);
    chk("idle.O0", 32'(ifc8.O), 32'h0);

    // One-shot from 3.
    cyc("os_load", 0, 1, 0, 0, 3);
    chk("os.O3", 32'(ifc8.O), 32'd3);
    cyc("os", 0, 0, 1, 0, 0);
    chk("os.O2", 32'(ifc8.O), 32'd2);
    cyc("os", 0, 0, 1, 0, 0);
    chk("os.O1", 32'(ifc8.O), 32'd1);
    cyc("os", 0, 0, 1, 0, 0);
    chk("os.O0", 32'(ifc8.O), 32'd0);
    chk("os.TC", 32'(ifc8.TC), 32'd1);
    cyc("os_done", 0, 0, 1, 0, 0);
    chk("os_done.TC", 32'(ifc8.TC), 32'd0);
    chk("os_done.RUN", 32'(ifc8.RUNNING), 32'd0);

    // Auto-reload with CE toggling: expect three expiries in twelve cycles.
    cyc("ar_load", 0, 1, 0, 1, 2);
    tc_seen = 0;
    for (int i = 0; i < 12; i++) cyc("ar", 0, 0, (i % 2) == 0, 1, 0);
    chk("ar.expiries", 32'(tc_seen), 32'd3);

    // Reload of 1: TC every enabled cycle, O stuck at 1; then zero load idles.
    cyc("r1_load", 0, 1, 0, 1, 1);
    tc_seen = 0;
    for (int i = 0; i < 4; i++) cyc("r1", 0, 0, 1, 1, 0);
    chk("r1.tc4", 32'(tc_seen), 32'd4);
    chk("r1.O1", 32'(ifc8.O), 32'd1);
    cyc("zero_load", 0, 1, 1, 1, 0);
    chk("zero.RUN", 32'(ifc8.RUNNING), 32'd0);

    // Load colliding with expiry, then reset mid-count.
    cyc("col_load", 0, 1, 0, 0, 5);
    for (int i = 0; i < 4; i++) cyc("col", 0, 0, 1, 0, 0);
    chk("col.pre_O1", 32'(ifc8.O), 32'd1);
    cyc("col_hit", 0, 1, 1, 0, 5);
    chk("col.O5", 32'(ifc8.O), 32'd5);
    chk("col.TC0", 32'(ifc8.TC), 32'd0);
    cyc("col", 0, 0, 1, 0, 0);
    cyc("col", 0, 0, 1, 0, 0);
    chk("col.O3", 32'(ifc8.O), 32'd3);
    cyc("mid_rst", 1, 0, 1, 0, 0);
    chk("mid_rst.O0", 32'(ifc8.O), 32'd0);

    // Random traffic; small load values keep expiries frequent.
    for (int i = 0; i < 400; i++) begin
      automatic bit r  = ($urandom_range(0, 49) == 0);
      automatic bit ld = ($urandom_range(0, 7) == 0);
      automatic bit ce = ($urandom_range(0, 3) != 0);
      automatic bit au = $urandom_range(0, 1) == 1;
      automatic int d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                     : int'($urandom_range(0, 6));
      cyc("rnd", r, ld, ce, au, d);
    end

    // 16-bit corner: full-scale one-shot, a single TC after 65535 enabled cycles.
    ifc16.LOAD = 1'b1; ifc16.D = 16'hFFFF;
    @(posedge clk); #1;
    chk("w16.load", 32'(ifc16.O), 32'hFFFF);
    ifc16.LOAD = 1'b0; ifc16.CE = 1'b1;
    @(posedge clk); #1;
    chk("w16.first", 32'(ifc16.O), 32'hFFFE);
    tc_seen = 0;
    for (int i = 1; i < 65535; i++) begin
      @(posedge clk); #1;
      if (ifc16.TC) tc_seen++;
    end
    chk("w16.O0", 32'(ifc16.O), 32'h0);
    chk("w16.TC", 32'(ifc16.TC), 32'd1);
    chk("w16.tc_count", 32'(tc_seen), 32'd1);
    @(posedge clk); #1;
    chk("w16.hold", 32'(ifc16.O), 32'h0);
    chk("w16.RUN", 32'(ifc16.RUNNING), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
